// File: rtl/irq_context_seq.sv
// Interrupt entry/exit sequencer: pushes PC/SR and vectors to ISR on entry, pops SR/PC and restores SP on RTI.
// Moore outputs decoded from state and captured registers; each memory request is held until mem_ready.
module irq_context_seq #(
  parameter logic [7:0]  IRQ_BANK = 8'hFF,
  parameter int unsigned IE_BIT   = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        irq_req,
  input  logic        boundary,
  input  logic        rti,
  input  logic [15:0] pc,
  input  logic [15:0] sr,
  input  logic [15:0] sp,
  input  logic [15:0] isr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        pc_load,
  output logic        sr_load,
  output logic        sp_load,
  output logic [15:0] pc_next,
  output logic [15:0] sr_next,
  output logic [15:0] sp_next,
  output logic        core_stall,
  output logic        irq_ack
);

  typedef enum logic [2:0] {
    IDLE, PUSH_PC, PUSH_SR, VECTOR, POP_SR, POP_PC, RESTORE
  } state_t;

  localparam logic [15:0] IE_MASK = 16'(16'h0001 << IE_BIT);

  state_t      state_q, state_d;
  logic [15:0] base_sp_q, base_sp_d;
  logic [15:0] saved_pc_q, saved_pc_d;
  logic [15:0] saved_sr_q, saved_sr_d;

  always_comb begin
    state_d    = state_q;
    base_sp_d  = base_sp_q;
    saved_pc_d = saved_pc_q;
    saved_sr_d = saved_sr_q;
    case (state_q)
      IDLE: begin
        // RTI wins over a simultaneous eligible interrupt
        if (rti) begin
          base_sp_d = sp;
          state_d   = POP_SR;
        end else if (boundary && irq_req && ((sr & IE_MASK) != 16'h0000)) begin
          base_sp_d  = sp;
          saved_pc_d = pc;
          saved_sr_d = sr;
          state_d    = PUSH_PC;
        end
      end
      PUSH_PC: if (mem_ready) state_d = PUSH_SR;
      PUSH_SR: if (mem_ready) state_d = VECTOR;
      VECTOR:  state_d = IDLE;
      POP_SR: begin
        if (mem_ready) begin
          saved_sr_d = mem_rdata;
          state_d    = POP_PC;
        end
      end
      POP_PC: begin
        if (mem_ready) begin
          saved_pc_d = mem_rdata;
          state_d    = RESTORE;
        end
      end
      RESTORE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      base_sp_q  <= 16'h0000;
      saved_pc_q <= 16'h0000;
      saved_sr_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      base_sp_q  <= base_sp_d;
      saved_pc_q <= saved_pc_d;
      saved_sr_q <= saved_sr_d;
    end
  end

  always_comb begin
    mem_addr   = 16'h0000;
    mem_wdata  = 16'h0000;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    pc_load    = 1'b0;
    sr_load    = 1'b0;
    sp_load    = 1'b0;
    pc_next    = 16'h0000;
    sr_next    = 16'h0000;
    sp_next    = 16'h0000;
    irq_ack    = 1'b0;
    core_stall = (state_q != IDLE);
    case (state_q)
      PUSH_PC: begin
        mem_we    = 1'b1;
        mem_addr  = base_sp_q - 16'd1;
        mem_wdata = saved_pc_q;
      end
      PUSH_SR: begin
        mem_we    = 1'b1;
        mem_addr  = base_sp_q - 16'd2;
        mem_wdata = saved_sr_q;
      end
      VECTOR: begin
        pc_load = 1'b1;
        pc_next = isr;
        sr_load = 1'b1;
        // Handler runs in the IRQ bank with interrupts masked
        sr_next = {IRQ_BANK, saved_sr_q[7:0] & ~IE_MASK[7:0]};
        sp_load = 1'b1;
        sp_next = base_sp_q - 16'd2;
        irq_ack = 1'b1;
      end
      POP_SR: begin
        mem_re   = 1'b1;
        mem_addr = base_sp_q;
      end
      POP_PC: begin
        mem_re   = 1'b1;
        mem_addr = base_sp_q + 16'd1;
      end
      RESTORE: begin
        pc_load = 1'b1;
        pc_next = saved_pc_q;
        sr_load = 1'b1;
        sr_next = saved_sr_q;
        sp_load = 1'b1;
        sp_next = base_sp_q + 16'd2;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_irq_context_seq.sv
// Scoreboard bench for irq_context_seq: expected stack traffic and register loads are queued at stimulus time.
module tb_irq_context_seq;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        irq_req = 1'b0, boundary = 1'b0, rti = 1'b0;
  logic [15:0] pc = 16'h0, sr = 16'h0, sp = 16'h0, isr = 16'h0;
  logic [15:0] mem_addr, mem_wdata, mem_rdata = 16'h0;
  logic        mem_we, mem_re, mem_ready = 1'b0;
  logic        pc_load, sr_load, sp_load, core_stall, irq_ack;
  logic [15:0] pc_next, sr_next, sp_next;

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic [15:0] addr; logic [15:0] data;} xfer_t;
  typedef struct packed {logic [15:0] pc; logic [15:0] sr; logic [15:0] sp;} load_t;
  xfer_t mem_q[$];
  load_t ld_q[$];

  always #5 clock = ~clock;

  irq_context_seq dut (
    .clock(clock), .reset_n(reset_n), .irq_req(irq_req), .boundary(boundary), .rti(rti),
    .pc(pc), .sr(sr), .sp(sp), .isr(isr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc_load(pc_load), .sr_load(sr_load), .sp_load(sp_load),
    .pc_next(pc_next), .sr_next(sr_next), .sp_next(sp_next),
    .core_stall(core_stall), .irq_ack(irq_ack)
  );

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({mem_addr, mem_wdata, mem_we, mem_re, pc_load, sr_load, sp_load,
         pc_next, sr_next, sp_next, core_stall, irq_ack} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: addr=%h wdata=%h we=%b re=%b stall=%b ack=%b, required all zero",
               mem_addr, mem_wdata, mem_we, mem_re, core_stall, irq_ack);
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_entry_case(input string name, input logic [15:0] sp_i, input logic [15:0] pc_i,
                                 input logic [15:0] sr_i, input logic [15:0] isr_i, input int waits);
    xfer_t x;
    load_t l;
    int stall_cnt = 0, wait_cnt = 0;
    bit done = 0;
    mem_q.push_back('{sp_i - 16'd1, pc_i});
    mem_q.push_back('{sp_i - 16'd2, sr_i});
    ld_q.push_back('{isr_i, {8'hFF, sr_i[7:1], 1'b0}, sp_i - 16'd2});
    sp = sp_i; pc = pc_i; sr = sr_i; isr = isr_i;
    irq_req = 1'b1; boundary = 1'b1; mem_ready = 1'b0;
    @(negedge clock);
    // Later changes to pc/sr/sp must not leak into the sequence
    irq_req = 1'b0; boundary = 1'b0; pc = 16'hDEAD; sr = 16'h0000; sp = 16'hBEEF;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      if (core_stall) stall_cnt++;
      if (mem_we === 1'b1) begin
        checks++;
        if (mem_q.size() == 0) begin
          errors++;
          $display("FAIL %s_extra_write: addr=%h data=%h, required no write", name, mem_addr, mem_wdata);
          mem_ready = 1'b1;
        end else begin
          x = mem_q[0];
          if (mem_addr !== x.addr || mem_wdata !== x.data || mem_re !== 1'b0) begin
            errors++;
            $display("FAIL %s_write: addr=%h data=%h re=%b, required addr=%h data=%h re=0",
                     name, mem_addr, mem_wdata, mem_re, x.addr, x.data);
          end
          if (wait_cnt < waits) begin
            mem_ready = 1'b0;
            wait_cnt++;
          end else begin
            mem_ready = 1'b1;
            wait_cnt = 0;
            void'(mem_q.pop_front());
          end
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      if (pc_load === 1'b1) begin
        checks++;
        if (ld_q.size() == 0) begin
          errors++;
          $display("FAIL %s_extra_load: pc_next=%h, required no load", name, pc_next);
        end else begin
          l = ld_q.pop_front();
          if (pc_next !== l.pc || sr_next !== l.sr || sp_next !== l.sp ||
              sr_load !== 1'b1 || sp_load !== 1'b1 || irq_ack !== 1'b1) begin
            errors++;
            $display("FAIL %s_vector: pc=%h sr=%h sp=%h ack=%b, required pc=%h sr=%h sp=%h ack=1",
                     name, pc_next, sr_next, sp_next, irq_ack, l.pc, l.sr, l.sp);
          end
        end
        done = 1;
      end
      @(negedge clock);
    end
    mem_ready = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: no vector load seen, required one within 60 cycles", name);
    end
    checks++;
    if (stall_cnt != 3 + 2 * waits) begin
      errors++;
      $display("FAIL %s_stall_cycles: got %0d, required %0d", name, stall_cnt, 3 + 2 * waits);
    end
    checks++;
    if (irq_ack !== 1'b0 || core_stall !== 1'b0 || pc_load !== 1'b0) begin
      errors++;
      $display("FAIL %s_after: ack=%b stall=%b pc_load=%b, required 0/0/0", name, irq_ack, core_stall, pc_load);
    end
    checks++;
    if (mem_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_writes: %0d left, required 0", name, mem_q.size());
    end
    mem_q.delete();
    ld_q.delete();
  endtask

  task automatic test_exit_case(input string name, input logic [15:0] sp_i, input logic [15:0] sr_mem,
                                input logic [15:0] pc_mem, input int waits, input bit with_irq);
    xfer_t x;
    load_t l;
    int stall_cnt = 0, wait_cnt = 0;
    bit done = 0;
    mem_q.push_back('{sp_i, sr_mem});
    mem_q.push_back('{sp_i + 16'd1, pc_mem});
    ld_q.push_back('{pc_mem, sr_mem, sp_i + 16'd2});
    sp = sp_i; rti = 1'b1;
    if (with_irq) begin
      irq_req = 1'b1; boundary = 1'b1; sr = 16'h0001; pc = 16'h1111;
    end
    @(negedge clock);
    rti = 1'b0; irq_req = 1'b0; boundary = 1'b0; sp = 16'h5555;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      if (core_stall) stall_cnt++;
      mem_rdata = 16'($urandom);
      if (mem_we === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected_write: addr=%h data=%h, required no write", name, mem_addr, mem_wdata);
      end
      if (mem_re === 1'b1) begin
        checks++;
        if (mem_q.size() == 0) begin
          errors++;
          $display("FAIL %s_extra_read: addr=%h, required no read", name, mem_addr);
          mem_ready = 1'b1;
        end else begin
          x = mem_q[0];
          if (mem_addr !== x.addr) begin
            errors++;
            $display("FAIL %s_read_addr: addr=%h, required %h", name, mem_addr, x.addr);
          end
          if (wait_cnt < waits) begin
            mem_ready = 1'b0;
            wait_cnt++;
          end else begin
            mem_ready = 1'b1;
            mem_rdata = x.data;
            wait_cnt = 0;
            void'(mem_q.pop_front());
          end
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      if (pc_load === 1'b1) begin
        checks++;
        if (ld_q.size() == 0) begin
          errors++;
          $display("FAIL %s_extra_load: pc_next=%h, required no load", name, pc_next);
        end else begin
          l = ld_q.pop_front();
          if (pc_next !== l.pc || sr_next !== l.sr || sp_next !== l.sp ||
              sr_load !== 1'b1 || sp_load !== 1'b1 || irq_ack !== 1'b0) begin
            errors++;
            $display("FAIL %s_restore: pc=%h sr=%h sp=%h ack=%b, required pc=%h sr=%h sp=%h ack=0",
                     name, pc_next, sr_next, sp_next, irq_ack, l.pc, l.sr, l.sp);
          end
        end
        done = 1;
      end
      @(negedge clock);
    end
    mem_ready = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: no restore load seen, required one within 60 cycles", name);
    end
    checks++;
    if (stall_cnt != 3 + 2 * waits) begin
      errors++;
      $display("FAIL %s_stall_cycles: got %0d, required %0d", name, stall_cnt, 3 + 2 * waits);
    end
    checks++;
    if (core_stall !== 1'b0 || pc_load !== 1'b0 || mem_re !== 1'b0) begin
      errors++;
      $display("FAIL %s_after: stall=%b pc_load=%b re=%b, required 0/0/0", name, core_stall, pc_load, mem_re);
    end
    mem_q.delete();
    ld_q.delete();
  endtask

  task automatic test_masking();
    for (int p = 0; p < 2; p++) begin
      irq_req  = 1'b1;
      boundary = (p == 0) ? 1'b1 : 1'b0;
      sr       = (p == 0) ? 16'hFFFE : 16'h0001;
      for (int c = 0; c < 4; c++) begin
        mem_ready = 1'($urandom_range(0, 1));
        @(negedge clock);
        checks++;
        if (core_stall !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0 || pc_load !== 1'b0) begin
          errors++;
          $display("FAIL mask_p%0d: stall=%b we=%b re=%b pc_load=%b, required all 0",
                   p, core_stall, mem_we, mem_re, pc_load);
        end
      end
    end
    irq_req = 1'b0; boundary = 1'b0; mem_ready = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    sp = 16'h2000; pc = 16'h0100; sr = 16'h0001; isr = 16'h8800;
    irq_req = 1'b1; boundary = 1'b1; mem_ready = 1'b1;
    @(negedge clock);
    irq_req = 1'b0; boundary = 1'b0;
    @(negedge clock);
    mem_ready = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h1FFE || mem_wdata !== 16'h0001) begin
      errors++;
      $display("FAIL rst_mid_push_sr: we=%b addr=%h data=%h, required 1/1ffe/0001", mem_we, mem_addr, mem_wdata);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({mem_addr, mem_wdata, mem_we, mem_re, pc_load, sr_load, sp_load,
         pc_next, sr_next, sp_next, core_stall, irq_ack} !== '0) begin
      errors++;
      $display("FAIL rst_mid_async: addr=%h we=%b stall=%b pc_load=%b, required all zero",
               mem_addr, mem_we, core_stall, pc_load);
    end
    for (int c = 0; c < 3; c++) begin
      mem_ready = 1'b1;
      @(negedge clock);
      checks++;
      if (pc_load !== 1'b0 || sr_load !== 1'b0 || sp_load !== 1'b0 || irq_ack !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_strobes: pc=%b sr=%b sp=%b ack=%b, required 0", pc_load, sr_load, sp_load, irq_ack);
      end
    end
    reset_n = 1'b1;
    mem_ready = 1'b0;
    @(negedge clock);
    test_entry_case("post_reset", 16'h2000, 16'h0100, 16'h0081, 16'h8800, 0);
  endtask

  initial begin
    test_reset();
    test_entry_case("entry", 16'h1000, 16'h0234, 16'h0001, 16'h8000, 0);
    test_exit_case("exit", 16'h0FFE, 16'h0001, 16'h0234, 0, 1'b0);
    test_entry_case("wait_entry", 16'h3000, 16'h1234, 16'h12A5, 16'h4000, 2);
    test_exit_case("wait_exit", 16'h2FFE, 16'h12A5, 16'h1234, 2, 1'b0);
    test_masking();
    test_exit_case("priority", 16'h4000, 16'hFF00, 16'h0777, 0, 1'b1);
    test_entry_case("wrap_entry", 16'h0001, 16'hABCD, 16'h0003, 16'h9000, 0);
    test_exit_case("wrap_exit", 16'hFFFF, 16'h0101, 16'h5A5A, 1, 1'b0);
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/irq_context_seq.md
# irq_context_seq

Interrupt entry/exit sequencer for the ToastCPU core. At an instruction boundary it takes a pending, enabled interrupt and does four things: stalls the core, pushes PC and SR to the stack through the data-memory port, switches the active register bank via SR[15:8], and vectors PC to the ISR register. On return-from-interrupt it pops SR and PC and restores SP. It sits between the core control unit, the register file special registers (ISR, SP, SR, PC) and the memory arbiter.

## Interface
Parameters:
- IRQ_BANK, 8'hFF: bank number written into SR[15:8] on interrupt entry.
- IE_BIT, 0: SR bit index of the global interrupt enable; cleared on entry.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- irq_req  in  1  level-sensitive interrupt request.
- boundary  in  1  core is at an instruction boundary and may be interrupted.
- rti  in  1  single-cycle pulse; core has decoded return-from-interrupt.
- pc, sr, sp, isr  in  16 each  current special-register values.
- mem_addr  out  16  memory request address.
- mem_wdata  out  16  memory write data.
- mem_we  out  1  write request.
- mem_re  out  1  read request.
- mem_rdata  in  16  read data, valid when mem_ready=1.
- mem_ready  in  1  request accepted/completed this cycle.
- pc_load, sr_load, sp_load  out  1 each  single-cycle register load strobes.
- pc_next, sr_next, sp_next  out  16 each  values to load.
- core_stall  out  1  holds the core pipeline.
- irq_ack  out  1  single-cycle pulse when the vector is taken.

## Operation
States: IDLE, PUSH_PC, PUSH_SR, VECTOR, POP_SR, POP_PC, RESTORE.

IDLE:
- If rti=1, capture sp into base_sp and go to POP_SR. rti takes priority over an interrupt in the same cycle.
- Otherwise, if boundary & irq_req & sr[IE_BIT], capture sp into base_sp, pc into saved_pc and sr into saved_sr, then go to PUSH_PC.

PUSH_PC:
- Drive mem_we=1, mem_addr=base_sp-1, mem_wdata=saved_pc.
- Go to PUSH_SR on the cycle mem_ready=1.

PUSH_SR:
- Drive mem_we=1, mem_addr=base_sp-2, mem_wdata=saved_sr.
- Go to VECTOR on mem_ready=1.

VECTOR, one cycle:
- pc_load=1, pc_next=isr.
- sr_load=1, sr_next={IRQ_BANK, saved_sr[7:0] with bit IE_BIT cleared}.
- sp_load=1, sp_next=base_sp-2.
- irq_ack=1.
- Go to IDLE.

POP_SR:
- Drive mem_re=1, mem_addr=base_sp.
- On mem_ready, latch mem_rdata into saved_sr and go to POP_PC.

POP_PC:
- Drive mem_re=1, mem_addr=base_sp+1.
- On mem_ready, latch mem_rdata into saved_pc and go to RESTORE.

RESTORE, one cycle:
- pc_load=1, pc_next=saved_pc.
- sr_load=1, sr_next=saved_sr. This restores the bank and the IE bit.
- sp_load=1, sp_next=base_sp+2.
- Go to IDLE.

Arithmetic and nesting rules:
- All address and SP arithmetic is 16-bit, modulo 2^16. Examples: base_sp=0x0000 pushes to 0xFFFF/0xFFFE; base_sp=0xFFFF pops from 0xFFFF/0x0000.
- Interrupts do not nest, because entry clears IE. An irq_req held during a handler is taken after RESTORE once boundary is high in IDLE.

## Timing
- Outputs are decoded from the state register and captured registers (Moore); there is no combinational path from irq_req to the memory outputs.
- Inputs pc, sr, sp and isr are sampled only at the IDLE decision edge (sp, pc, sr) or during VECTOR (isr). Later changes to pc/sr/sp have no effect.
- core_stall=1 in every state except IDLE.
- Memory handshake:
  - The request is held stable (address, data, strobe) until mem_ready=1 is sampled.
  - A transfer completes in the cycle mem_ready=1; mem_ready in a non-request state is ignored.
  - Only one of mem_we/mem_re is ever high.
- With mem_ready tied high, entry is 3 cycles (PUSH_PC, PUSH_SR, VECTOR) after the decision edge, and exit is 3 cycles (POP_SR, POP_PC, RESTORE).
- Each wait cycle with mem_ready=0 adds one cycle.
- Reset: state=IDLE, all outputs 0 (mem_addr/mem_wdata/pc_next/sr_next/sp_next=16'h0000), captured registers cleared.
- Reset mid-sequence aborts the sequence with no load strobes issued. Partial stack writes already done are not undone.

## Test plan
- Entry: sp=0x1000, pc=0x0234, sr=0x0001, isr=0x8000, irq_req=1, boundary=1, mem_ready=1.
  - Expect write 0x0234@0x0FFF, then write 0x0001@0x0FFE.
  - Then VECTOR: pc_next=0x8000, sr_next=0xFF00, sp_next=0x0FFE, irq_ack for 1 cycle; core_stall for 3 cycles.
- Exit: rti pulse with sp=0x0FFE, memory returns 0x0001@0x0FFE and 0x0234@0x0FFF.
  - Expect pc_next=0x0234, sr_next=0x0001, sp_next=0x1000.
- Memory wait states: mem_ready=0 for 2 cycles on each access.
  - Expect request signals constant during waits, entry taking 7 cycles total, and correct final loads.
- Masking and priority:
  - irq_req=1 with sr[0]=0, or with boundary=0, must stay in IDLE with no stall.
  - rti and an eligible irq in the same cycle must take the POP path.
- Wrap-around: sp=0x0001 on entry must write to 0x0000 then 0xFFFF, with sp_next=0xFFFF.
- Reset in PUSH_SR (reset_n low mid-cycle, asynchronously):
  - All outputs go to 0 immediately and no load strobes are issued.
  - After release, a new irq is taken normally.
